mult_inverse_div48x18: RTL and testbench
========================================

Name: mult_inverse_div48x18

Overview:
- Iterative restoring divider that inverts the DSP multiply-add relation Z = A*B + C.
- Given Z, C and B, it recovers A = trunc((Z - C) / B) as an 18-bit quotient, plus the remainder.
- Used in the sincos linear path wherever a product/offset must be mapped back to an operand, e.g. slope/segment recovery.
- One operand set per transaction, start/busy/done handshake, fixed latency.

Parameters:
- SIGNED_MODE, "SIGNED": "SIGNED" or "UNSIGNED" interpretation of Z, C and B.
- SATURATE, "ENABLED": "ENABLED" clamps Q on overflow; "DISABLED" outputs the low 18 bits of the magnitude quotient, sign applied.

Ports:
- clk  input  1  clock.
- reset  input  1  reset; asynchronous, active-high.
- start  input  1  request; sampled only in IDLE.
- Z  input  48  dividend source.
- C  input  48  offset subtracted from Z.
- B  input  18  divisor.
- busy  output  1  high while a transaction is in progress.
- done  output  1  one-cycle pulse; Q/R/ovf/dz valid.
- Q  output  18  quotient.
- R  output  18  remainder; sign follows the dividend, |R| < |B|.
- ovf  output  1  quotient out of range or divide-by-zero.
- dz  output  1  B == 0.

Behaviour:
- Reset (async, immediate): state IDLE. busy, done, Q, R, ovf and dz are all 0.
- States:
  - IDLE -> PREP on start.
  - PREP -> DIV.
  - DIV stays for 18 iterations, then -> FIX.
  - FIX -> IDLE.
- Edge e0 (IDLE, start=1): capture Z, C, B; state PREP; busy=1 from e0.
- PREP, e1:
  - num = Z - C, computed at 49 bits (sign-extended in SIGNED mode, zero-extended in UNSIGNED mode).
  - Take magnitudes |num| (49b) and |B| (18b); record the result sign (sign num XOR sign B) and the remainder sign (sign num).
  - Pre-overflow: |num| >= (|B| << 18) sets the ovf flag.
  - UNSIGNED mode: num < 0 sets the ovf flag.
  - B == 0 sets dz=1 and ovf=1.
- DIV, e2..e19: one restoring step per edge, quotient bits 17 down to 0.
  - Partial remainder is 19 bits; compare/subtract against |B|.
  - 5-bit iteration counter.
  - The iterations run even when ovf or dz is set, so latency is fixed.
- FIX, e20: register the outputs, then done=1 and busy=0 for one cycle.
  - Q = sign-applied magnitude quotient. Signed range is -131072..131071; UNSIGNED range is 0..262143.
  - Signed overflow when magnitude > 131071 with a positive result, or > 131072 with a negative result.
  - Overflow with SATURATE enabled: Q = 131071 (positive) or -131072 (negative); R = 0.
  - dz: Q = 131071 if num >= 0, otherwise -131072; R = 0. UNSIGNED dz gives Q = 262143.
- Latency: done high in the cycle after e20, exactly 20 edges after the start-sampling edge.
- Q/R/ovf/dz hold until the next FIX or reset.
- start while busy: ignored, with no queueing.
- start in the done cycle: accepted, since the state is already IDLE.
- done never asserts without a prior accepted start.
- reset mid-transaction: abort, outputs cleared, no done.
- Arithmetic is truncation toward zero; the identity Z - C = Q*B + R holds whenever ovf=0.

Decomposition:
- Package mult_inverse_pkg holds:
  - the state enum (IDLE, PREP, DIV, FIX);
  - the width constants QW=18, ZW=48, NW=49;
  - the iteration count 18;
  - the saturation constants QMAX_S=131071, QMIN_S=-131072, QMAX_U=262143.
- One natural sub-module, div_restore_step: purely combinational single restoring step.
  - Inputs: 19-bit partial remainder, next dividend bit, 18-bit divisor.
  - Outputs: new partial remainder and quotient bit.
  - Instantiated once and reused across iterations.

Test Plan:
- Z=1000, C=0, B=7, start at e0 -> done in the cycle after e20; Q=142, R=6, ovf=0, dz=0; busy high e0..e20.
- Z=-1000, C=0, B=7 -> Q=-142, R=-6. Z=0, C=-100, B=-3 -> Q=-33, R=1, ovf=0.
- B=0, Z=5, C=0 -> dz=1, ovf=1, Q=131071, R=0, same 20-edge latency.
- Z=2^40, C=0, B=1 -> ovf=1, Q=131071. Z=-131072, B=1 -> Q=-131072, ovf=0. Z=131072, B=1 -> ovf=1, Q=131071.
- UNSIGNED mode: Z=10, C=20, B=3 -> ovf=1, Q=0 (SATURATE gives 0 for a negative result in unsigned mode). Z=262143*5, C=0, B=5 -> Q=262143, ovf=0.
- Handshake and reset:
  - start pulsed at e5 during busy -> ignored, only one done.
  - start held through the done cycle -> second transaction accepted.
  - reset asserted at iteration 10 -> busy=0, done=0, Q=0 immediately.
  - Fresh start after reset (Z=1000, C=0, B=7) -> Q=142.

Source files
------------

// File: rtl/mult_inverse_pkg.sv
// Shared types and constants for the multiply-inverse divider.
// State encoding, datapath widths and saturation limits.
package mult_inverse_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PREP,
    DIV,
    FIX
  } state_t;

  localparam int QW = 18;
  localparam int ZW = 48;
  localparam int NW = 49;

  localparam logic [4:0] NITER = 5'd18;

  // 131071, -131072 and 262143 as 18-bit patterns
  localparam logic [QW-1:0] QMAX_S = 18'h1FFFF;
  localparam logic [QW-1:0] QMIN_S = 18'h20000;
  localparam logic [QW-1:0] QMAX_U = 18'h3FFFF;

endpackage

// File: rtl/div_restore_step.sv
// One combinational restoring-division step.
// pr_i/bit_i/d_i: partial rem, next dividend bit, divisor;
// pr_o/q_o: new partial remainder and quotient bit.
module div_restore_step
  import mult_inverse_pkg::*;
(
  input  logic [QW:0]   pr_i,
  input  logic          bit_i,
  input  logic [QW-1:0] d_i,
  output logic [QW:0]   pr_o,
  output logic          q_o
);

  logic [QW+1:0] t;
  logic [QW:0]   diff;

  assign t    = {pr_i, bit_i};
  // pr_i < d_i holds, so the shifted value always fits in QW+1 bits
  assign diff = t[QW:0] - {1'b0, d_i};
  assign q_o  = (t >= {2'b00, d_i});
  assign pr_o = q_o ? diff : t[QW:0];

endmodule

// File: rtl/mult_inverse_div48x18.sv
// Recovers A = trunc((Z - C) / B) with an 18-step restoring divider.
// start/busy/done handshake; Q, R, ovf, dz held until the next result.
module mult_inverse_div48x18
  import mult_inverse_pkg::*;
#(
  parameter string SIGNED_MODE = "SIGNED",
  parameter string SATURATE    = "ENABLED"
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [ZW-1:0] Z,
  input  logic [ZW-1:0] C,
  input  logic [QW-1:0] B,
  output logic          busy,
  output logic          done,
  output logic [QW-1:0] Q,
  output logic [QW-1:0] R,
  output logic          ovf,
  output logic          dz
);

  localparam bit SGN = (SIGNED_MODE == "SIGNED");
  localparam bit SAT = (SATURATE == "ENABLED");

  state_t        state_q;
  logic [ZW-1:0] z_q, c_q;
  logic [QW-1:0] b_q, absb_q, dq_q;
  logic [QW:0]   pr_q;
  logic [4:0]    cnt_q;
  logic          neg_q, rneg_q, ovfp_q, dzp_q;
  logic          busy_q, done_q, ovf_q, dz_q;
  logic [QW-1:0] q_q, r_q;

  logic [NW-1:0] zx, cx, num, absnum;
  logic [QW-1:0] absb;
  logic          nneg, bneg, pre_ovf;

  always_comb begin
    zx      = SGN ? {z_q[ZW-1], z_q} : {1'b0, z_q};
    cx      = SGN ? {c_q[ZW-1], c_q} : {1'b0, c_q};
    num     = zx - cx;
    nneg    = num[NW-1];
    bneg    = SGN & b_q[QW-1];
    absnum  = nneg ? -num : num;
    absb    = bneg ? -b_q : b_q;
    // quotient magnitude would not fit in QW bits
    pre_ovf = absnum >= {{(NW-2*QW){1'b0}}, absb, {QW{1'b0}}};
  end

  logic [QW:0] step_pr;
  logic        step_q;

  div_restore_step u_step (
    .pr_i  (pr_q),
    .bit_i (dq_q[QW-1]),
    .d_i   (absb_q),
    .pr_o  (step_pr),
    .q_o   (step_q)
  );

  logic [QW-1:0] qs, rs, q_d, r_d;
  logic          rng, ovf_d;

  always_comb begin
    qs = neg_q ? -dq_q : dq_q;
    rs = rneg_q ? -pr_q[QW-1:0] : pr_q[QW-1:0];
    if (SGN) begin
      rng = neg_q ? (dq_q > QMIN_S) : (dq_q > QMAX_S);
    end else begin
      rng = 1'b0;
    end
    ovf_d = ovfp_q | rng;
    q_d   = qs;
    r_d   = rs;
    if (dzp_q) begin
      r_d = '0;
      if (!SGN) q_d = QMAX_U;
      else      q_d = rneg_q ? QMIN_S : QMAX_S;
    end else if (ovf_d && SAT) begin
      r_d = '0;
      if (!SGN) q_d = neg_q ? '0 : QMAX_U;
      else      q_d = neg_q ? QMIN_S : QMAX_S;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      z_q     <= '0;
      c_q     <= '0;
      b_q     <= '0;
      absb_q  <= '0;
      dq_q    <= '0;
      pr_q    <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      ovfp_q  <= 1'b0;
      dzp_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            z_q     <= Z;
            c_q     <= C;
            b_q     <= B;
            busy_q  <= 1'b1;
            state_q <= PREP;
          end
        end
        PREP: begin
          absb_q  <= absb;
          pr_q    <= {1'b0, absnum[2*QW-1:QW]};
          dq_q    <= absnum[QW-1:0];
          neg_q   <= nneg ^ bneg;
          rneg_q  <= nneg;
          ovfp_q  <= pre_ovf | (!SGN & nneg) | (b_q == '0);
          dzp_q   <= (b_q == '0);
          cnt_q   <= '0;
          state_q <= DIV;
        end
        DIV: begin
          // dq_q shifts dividend bits out and quotient bits in
          pr_q  <= step_pr;
          dq_q  <= {dq_q[QW-2:0], step_q};
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == NITER - 5'd1) state_q <= FIX;
        end
        FIX: begin
          q_q     <= q_d;
          r_q     <= r_d;
          ovf_q   <= ovf_d;
          dz_q    <= dzp_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign Q    = q_q;
  assign R    = r_q;
  assign ovf  = ovf_q;
  assign dz   = dz_q;

endmodule

// File: tb/tb_mult_inverse_div48x18.sv
// Directed bench for mult_inverse_div48x18, signed and unsigned builds.
// Each scenario task checks its own hand-computed results.
module tb_mult_inverse_div48x18;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start_s = 1'b0;
  logic        start_u = 1'b0;
  logic [47:0] Z = '0;
  logic [47:0] C = '0;
  logic [17:0] B = '0;

  logic        busy_s, done_s, ovf_s, dz_s;
  logic        busy_u, done_u, ovf_u, dz_u;
  logic [17:0] q_s, r_s, q_u, r_u;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mult_inverse_div48x18 #(
    .SIGNED_MODE ("SIGNED"),
    .SATURATE    ("ENABLED")
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start_s),
    .Z     (Z),
    .C     (C),
    .B     (B),
    .busy  (busy_s),
    .done  (done_s),
    .Q     (q_s),
    .R     (r_s),
    .ovf   (ovf_s),
    .dz    (dz_s)
  );

  mult_inverse_div48x18 #(
    .SIGNED_MODE ("UNSIGNED"),
    .SATURATE    ("ENABLED")
  ) dut_u (
    .clk   (clk),
    .reset (reset),
    .start (start_u),
    .Z     (Z),
    .C     (C),
    .B     (B),
    .busy  (busy_u),
    .done  (done_u),
    .Q     (q_u),
    .R     (r_u),
    .ovf   (ovf_u),
    .dz    (dz_u)
  );

  // signed vectors: Z, C, B -> Q, R, ovf, dz
  logic [47:0] sz [8] = '{48'd1000, -48'sd1000, 48'd0, 48'd5,
                          48'h0100_0000_0000, 48'hFFFF_FFFE_0000,
                          48'd131072, 48'd1000};
  logic [47:0] sc [8] = '{48'd0, 48'd0, -48'sd100, 48'd0,
                          48'd0, 48'd0, 48'd0, 48'd300};
  logic [17:0] sb [8] = '{18'd7, 18'd7, 18'h3FFFD, 18'd0,
                          18'd1, 18'd1, 18'd1, 18'h3FFF9};
  logic [17:0] sq [8] = '{18'd142, 18'h3FF72, 18'h3FFDF, 18'h1FFFF,
                          18'h1FFFF, 18'h20000, 18'h1FFFF, 18'h3FF9C};
  logic [17:0] sr [8] = '{18'd6, 18'h3FFFA, 18'd1, 18'd0,
                          18'd0, 18'd0, 18'd0, 18'd0};
  logic [1:0]  sf [8] = '{2'b00, 2'b00, 2'b00, 2'b11,
                          2'b10, 2'b00, 2'b10, 2'b00};

  // drives one transaction; returns at the done cycle (or after 40 edges)
  task automatic txn(input logic u, input logic [47:0] z, c,
                     input logic [17:0] b, output int lat,
                     output logic bok, output logic [37:0] res);
    logic hit;
    Z = z;
    C = c;
    B = b;
    if (u) start_u = 1'b1;
    else   start_s = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_s = 1'b0;
    start_u = 1'b0;
    bok = u ? busy_u : busy_s;
    lat = 0;
    hit = 1'b0;
    res = '0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (u ? done_u : done_s) begin
        hit = 1'b1;
        bok = bok & !(u ? busy_u : busy_s);
        res = u ? {q_u, r_u, ovf_u, dz_u} : {q_s, r_s, ovf_s, dz_s};
        break;
      end
      bok = bok & (u ? busy_u : busy_s);
    end
    if (!hit) lat = 99;
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({busy_s, done_s, q_s, r_s, ovf_s, dz_s} !== 40'd0) begin
      bad++;
      $display("FAIL reset_s got=%h exp=0",
               {busy_s, done_s, q_s, r_s, ovf_s, dz_s});
    end
    total++;
    if ({busy_u, done_u, q_u, r_u, ovf_u, dz_u} !== 40'd0) begin
      bad++;
      $display("FAIL reset_u got=%h exp=0",
               {busy_u, done_u, q_u, r_u, ovf_u, dz_u});
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_signed();
    int lat;
    logic bok;
    logic [37:0] res, exp;
    for (int i = 0; i < 8; i++) begin
      txn(1'b0, sz[i], sc[i], sb[i], lat, bok, res);
      exp = {sq[i], sr[i], sf[i]};
      total++;
      if (res !== exp) begin
        bad++;
        $display("FAIL sgn_res[%0d] got=%h exp=%h", i, res, exp);
      end
      total++;
      if (lat !== 20) begin
        bad++;
        $display("FAIL sgn_lat[%0d] got=%0d exp=20", i, lat);
      end
      total++;
      if (bok !== 1'b1) begin
        bad++;
        $display("FAIL sgn_busy[%0d] got=%b exp=1", i, bok);
      end
    end
  endtask

  task automatic test_unsigned();
    int lat;
    logic bok;
    logic [37:0] res;
    txn(1'b1, 48'd10, 48'd20, 18'd3, lat, bok, res);
    total++;
    if (res !== {18'd0, 18'd0, 2'b10}) begin
      bad++;
      $display("FAIL uns_neg got=%h exp=%h", res, {18'd0, 18'd0, 2'b10});
    end
    total++;
    if (lat !== 20) begin
      bad++;
      $display("FAIL uns_lat got=%0d exp=20", lat);
    end
    txn(1'b1, 48'd1310715, 48'd0, 18'd5, lat, bok, res);
    total++;
    if (res !== {18'h3FFFF, 18'd0, 2'b00}) begin
      bad++;
      $display("FAIL uns_max got=%h exp=%h", res,
               {18'h3FFFF, 18'd0, 2'b00});
    end
    total++;
    if (bok !== 1'b1) begin
      bad++;
      $display("FAIL uns_busy got=%b exp=1", bok);
    end
  endtask

  task automatic test_ignore_start();
    int nd, first;
    nd = 0;
    first = -1;
    Z = 48'd1000;
    C = 48'd0;
    B = 18'd7;
    start_s = 1'b1;
    for (int k = 0; k < 45; k++) begin
      @(posedge clk);
      @(negedge clk);
      start_s = (k == 4);
      if (done_s) begin
        nd++;
        if (first < 0) first = k;
      end
    end
    start_s = 1'b0;
    total++;
    if (nd !== 1) begin
      bad++;
      $display("FAIL ignore_cnt got=%0d exp=1", nd);
    end
    total++;
    if (first !== 20) begin
      bad++;
      $display("FAIL ignore_at got=%0d exp=20", first);
    end
  endtask

  task automatic test_back_to_back();
    int nd, d0, d1;
    logic [17:0] q0, q1;
    nd = 0;
    d0 = -1;
    d1 = -1;
    q0 = '0;
    q1 = '0;
    Z = 48'd1000;
    C = 48'd0;
    B = 18'd7;
    start_s = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 21) start_s = 1'b0;
      if (done_s) begin
        nd++;
        if (d0 < 0) begin
          d0 = k;
          q0 = q_s;
          Z = 48'd2000;
        end else begin
          d1 = k;
          q1 = q_s;
        end
      end
    end
    start_s = 1'b0;
    total++;
    if (nd !== 2) begin
      bad++;
      $display("FAIL b2b_cnt got=%0d exp=2", nd);
    end
    total++;
    if ({d0, d1} !== {32'd20, 32'd41}) begin
      bad++;
      $display("FAIL b2b_at got=%0d,%0d exp=20,41", d0, d1);
    end
    total++;
    if (q0 !== 18'd142) begin
      bad++;
      $display("FAIL b2b_q0 got=%0d exp=142", q0);
    end
    total++;
    if ({q1, r_s} !== {18'd285, 18'd5}) begin
      bad++;
      $display("FAIL b2b_q1 got=%0d/%0d exp=285/5", q1, r_s);
    end
  endtask

  task automatic test_reset_abort();
    int nd;
    int lat;
    logic bok;
    logic [37:0] res;
    Z = 48'd1000;
    C = 48'd0;
    B = 18'd7;
    start_s = 1'b1;
    for (int k = 0; k < 11; k++) begin
      @(posedge clk);
      @(negedge clk);
      start_s = 1'b0;
    end
    #1 reset = 1'b1;
    #1;
    total++;
    if ({busy_s, done_s, q_s, r_s, ovf_s, dz_s} !== 40'd0) begin
      bad++;
      $display("FAIL abort_clr got=%h exp=0",
               {busy_s, done_s, q_s, r_s, ovf_s, dz_s});
    end
    @(negedge clk);
    reset = 1'b0;
    nd = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done_s) nd++;
    end
    total++;
    if (nd !== 0) begin
      bad++;
      $display("FAIL abort_done got=%0d exp=0", nd);
    end
    txn(1'b0, 48'd1000, 48'd0, 18'd7, lat, bok, res);
    total++;
    if (res !== {18'd142, 18'd6, 2'b00}) begin
      bad++;
      $display("FAIL after_rst got=%h exp=%h", res,
               {18'd142, 18'd6, 2'b00});
    end
  endtask

  initial begin
    test_reset();
    test_signed();
    test_unsigned();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
